// File: rtl/ofdm_pkg.sv
// Shared OFDM constants and types for the cyclic-prefix serializer.
package ofdm_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_N_POINTS = 8;
    localparam int unsigned DEF_CP_LEN   = 2;
    localparam int unsigned SYM_LEN      = DEF_N_POINTS + DEF_CP_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        DATA = 2'd2
    } cp_state_e;

    // Index of the first sample copied into the cyclic prefix.
    function automatic int unsigned cp_first_idx(input int unsigned n_points,
                                                 input int unsigned cp_len);
        return n_points - cp_len;
    endfunction

endpackage

// File: rtl/cp_symbol_buffer.sv
// Two-bank ping-pong symbol store. Banks are filled and drained strictly in capture order,
// so the write pointer always names the free bank whenever any bank is free.
module cp_symbol_buffer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_POINTS = 8,
    parameter int unsigned IDX_W    = $clog2(N_POINTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [N_POINTS*DATA_W-1:0] wr_re,
    input  logic [N_POINTS*DATA_W-1:0] wr_im,
    input  logic                       rd_free,
    input  logic                       rd_next,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [1:0]                 full,
    output logic                       cur_full,
    output logic                       next_full,
    output logic [DATA_W-1:0]          rd_re,
    output logic [DATA_W-1:0]          rd_im
);

    logic [DATA_W-1:0] mem_re [2][N_POINTS];
    logic [DATA_W-1:0] mem_im [2][N_POINTS];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic              rd_bank;

    // Bank storage: capture all samples of a symbol into the write bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < N_POINTS; k++) begin
                mem_re[wr_ptr_q][k] <= wr_re[k*DATA_W +: DATA_W];
                mem_im[wr_ptr_q][k] <= wr_im[k*DATA_W +: DATA_W];
            end
        end
    end

    // Full flags: a free and a capture in the same cycle always hit different banks.
    always_comb begin
        full_d = full_q;
        if (rd_free) begin
            full_d[rd_ptr_q] = 1'b0;
        end
        if (wr_en) begin
            full_d[wr_ptr_q] = 1'b1;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= 2'b00;
        end else begin
            full_q <= full_d;
            if (wr_en) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_free) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Read mux: rd_next selects the following bank while the current one is being released.
    always_comb begin
        rd_bank = rd_ptr_q ^ rd_next;
        rd_re   = mem_re[rd_bank][rd_idx];
        rd_im   = mem_im[rd_bank][rd_idx];
    end

    assign full      = full_q;
    assign cur_full  = full_q[rd_ptr_q];
    assign next_full = full_q[~rd_ptr_q];

endmodule

// File: rtl/cp_insert_serializer.sv
// Cyclic-prefix insertion and parallel-to-serial conversion of IFFT output symbols.
// Emits samples N-CP_LEN..N-1 followed by 0..N-1 through a registered valid/ready port.
module cp_insert_serializer
    import ofdm_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned N_POINTS = DEF_N_POINTS,
    parameter int unsigned CP_LEN   = DEF_CP_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_POINTS*DATA_W-1:0] in_re,
    input  logic [N_POINTS*DATA_W-1:0] in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_re,
    output logic [DATA_W-1:0]          out_im,
    output logic                       out_sop,
    output logic                       out_eop
);

    localparam int unsigned    IDX_W       = $clog2(N_POINTS);
    localparam bit             HAS_CP      = (CP_LEN > 0);
    localparam logic [IDX_W-1:0] CP_BASE   = IDX_W'(cp_first_idx(N_POINTS, CP_LEN));
    localparam logic [IDX_W-1:0] CP_LAST   = IDX_W'(HAS_CP ? CP_LEN - 1 : 0);
    localparam logic [IDX_W-1:0] N_LAST    = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = HAS_CP ? CP_BASE : IDX_W'(0);
    localparam cp_state_e      START_ST    = HAS_CP ? CP : DATA;

    cp_state_e          state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   cnt_inc;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  re_q, re_d;
    logic [DATA_W-1:0]  im_q, im_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;

    logic               xfer;
    logic               load;
    logic               wr_en;
    logic               rd_free;
    logic               rd_next;
    logic [IDX_W-1:0]   rd_idx;
    logic [1:0]         full;
    logic               cur_full;
    logic               next_full;
    logic [DATA_W-1:0]  rd_re;
    logic [DATA_W-1:0]  rd_im;

    assign in_ready = ~(full[0] & full[1]);
    assign wr_en    = in_valid & in_ready;
    assign xfer     = valid_q & out_ready;
    assign cnt_inc  = cnt_q + IDX_W'(1);

    cp_symbol_buffer #(
        .DATA_W   (DATA_W),
        .N_POINTS (N_POINTS),
        .IDX_W    (IDX_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_re     (in_re),
        .wr_im     (in_im),
        .rd_free   (rd_free),
        .rd_next   (rd_next),
        .rd_idx    (rd_idx),
        .full      (full),
        .cur_full  (cur_full),
        .next_full (next_full),
        .rd_re     (rd_re),
        .rd_im     (rd_im)
    );

    // Next-state logic: state/counter describe the sample currently held in the output register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        re_d    = re_q;
        im_d    = im_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        rd_free = 1'b0;
        rd_next = 1'b0;
        rd_idx  = '0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cur_full) begin
                    state_d = START_ST;
                    cnt_d   = '0;
                    rd_idx  = FIRST_IDX;
                    load    = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = 1'b0;
                end
            end
            CP: begin
                if (xfer) begin
                    load  = 1'b1;
                    sop_d = 1'b0;
                    eop_d = 1'b0;
                    if (cnt_q == CP_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        rd_idx  = '0;
                    end else begin
                        cnt_d  = cnt_inc;
                        rd_idx = CP_BASE + cnt_inc;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (cnt_q == N_LAST) begin
                        rd_free = 1'b1;
                        if (next_full) begin
                            // Chain straight into the next bank to avoid a bubble.
                            rd_next = 1'b1;
                            state_d = START_ST;
                            cnt_d   = '0;
                            rd_idx  = FIRST_IDX;
                            load    = 1'b1;
                            sop_d   = 1'b1;
                            eop_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            valid_d = 1'b0;
                            re_d    = '0;
                            im_d    = '0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_inc;
                        rd_idx = cnt_inc;
                        load   = 1'b1;
                        sop_d  = 1'b0;
                        eop_d  = (cnt_inc == N_LAST);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
                re_d    = '0;
                im_d    = '0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase

        if (load) begin
            valid_d = 1'b1;
            re_d    = rd_re;
            im_d    = rd_im;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            re_q    <= re_d;
            im_q    <= im_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;

endmodule

// File: tb/tb_cp_insert_serializer.sv
// Directed bench: CP_LEN=2 main instance plus CP_LEN=0 and CP_LEN=8 instances.
module tb_cp_insert_serializer;

    logic         clk;
    logic         rst;
    logic         ordy;
    logic [127:0] in_re;
    logic [127:0] in_im;

    logic         iv2, ir2, ov2, sop2, eop2;
    logic [15:0]  re2, im2;
    logic         iv0, ir0, ov0, sop0, eop0;
    logic [15:0]  re0, im0;
    logic         iv8, ir8, ov8, sop8, eop8;
    logic [15:0]  re8, im8;

    logic [15:0]  sre [4][8];
    logic [15:0]  sim [4][8];

    logic [33:0]  q2 [$];
    logic [33:0]  q0 [$];
    logic [33:0]  q8 [$];
    logic         acc2;

    int checks = 0;
    int errors = 0;

    cp_insert_serializer #(.DATA_W(16), .N_POINTS(8), .CP_LEN(2)) dut (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_re(in_re), .in_im(in_im),
        .out_valid(ov2), .out_ready(ordy), .out_re(re2), .out_im(im2),
        .out_sop(sop2), .out_eop(eop2)
    );

    cp_insert_serializer #(.DATA_W(16), .N_POINTS(8), .CP_LEN(0)) dut_cp0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_re(in_re), .in_im(in_im),
        .out_valid(ov0), .out_ready(ordy), .out_re(re0), .out_im(im0),
        .out_sop(sop0), .out_eop(eop0)
    );

    cp_insert_serializer #(.DATA_W(16), .N_POINTS(8), .CP_LEN(8)) dut_cp8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_re(in_re), .in_im(in_im),
        .out_valid(ov8), .out_ready(ordy), .out_re(re8), .out_im(im8),
        .out_sop(sop8), .out_eop(eop8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called with inputs settled between negedge and posedge; logs transfers, then advances.
    task automatic cyc();
        acc2 = 1'b0;
        if (!rst) begin
            if (ov2 && ordy) q2.push_back({sop2, eop2, re2, im2});
            if (ov0 && ordy) q0.push_back({sop0, eop0, re0, im0});
            if (ov8 && ordy) q8.push_back({sop8, eop8, re8, im8});
            acc2 = iv2 && ir2;
        end
        @(negedge clk);
    endtask

    task automatic drive_sym(input int s);
        for (int k = 0; k < 8; k++) begin
            in_re[k*16 +: 16] = sre[s][k];
            in_im[k*16 +: 16] = sim[s][k];
        end
    endtask

    function automatic logic [33:0] exp_item(input int s, input int cp, input int k);
        int idx;
        idx = (k < cp) ? (8 - cp + k) : (k - cp);
        return {(k == 0), (k == 8 + cp - 1), sre[s][idx], sim[s][idx]};
    endfunction

    task automatic check_stream(input string tag, input logic [33:0] q[$], input int cp,
                                input int s0, input int nsym);
        int len;
        len = nsym * (8 + cp);
        chk({tag, "_len"}, 64'(q.size()), 64'(len));
        for (int j = 0; j < len && j < q.size(); j++) begin
            chk($sformatf("%s[%0d]", tag, j), 64'(q[j]), 64'(exp_item(s0 + j / (8 + cp), cp,
                                                                          j % (8 + cp))));
        end
    endtask

    // Offers symbols 1..3 back-to-back to the main instance and drains 30 samples.
    task automatic run_stream(input bit rnd, input int budget);
        int          sent;
        int          bubbles;
        bit          started;
        bit          stalled;
        bit          eopx;
        bit          first_eop;
        bit          low_seen;
        logic        pre_ready;
        logic [33:0] held;
        sent = 0; bubbles = 0; started = 0; first_eop = 1; low_seen = 0;
        q2.delete();
        drive_sym(1);
        iv2 = 1'b1;
        for (int c = 0; c < budget && q2.size() < 30; c++) begin
            ordy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = ov2 && !ordy;
            held      = {sop2, eop2, re2, im2};
            eopx      = ov2 && ordy && eop2;
            pre_ready = ir2;
            if (started && !ov2) bubbles++;
            if (ov2) started = 1;
            if (iv2 && !ir2) low_seen = 1;
            cyc();
            if (acc2) begin
                sent++;
                if (sent < 3) drive_sym(sent + 1);
                else iv2 = 1'b0;
            end
            if (stalled) chk("stall_hold", 64'({sop2, eop2, re2, im2}), 64'(held));
            if (eopx && first_eop && !rnd) begin
                first_eop = 0;
                chk("rdy_before_eop", 64'(pre_ready), 64'(0));
                chk("rdy_after_eop", 64'(ir2), 64'(1));
            end
        end
        ordy = 1'b1;
        iv2  = 1'b0;
        chk("sent", 64'(sent), 64'(3));
        if (!rnd) begin
            chk("bubbles", 64'(bubbles), 64'(0));
            chk("ready_low", 64'(low_seen), 64'(1));
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                if (s == 0) begin
                    sre[s][k] = 16'(k + 1);
                    sim[s][k] = 16'(-(k + 1));
                end else begin
                    sre[s][k] = 16'(s * 16 + k);
                    sim[s][k] = 16'(32'h100 * s + 3 * k);
                end
            end
        end
        rst = 1'b1; ordy = 1'b1; iv2 = 1'b0; iv0 = 1'b0; iv8 = 1'b0;
        in_re = '0; in_im = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc();
        rst = 1'b0;

        // Reset state.
        chk("rst_ov", 64'(ov2), 64'(0));
        chk("rst_re", 64'(re2), 64'(0));
        chk("rst_im", 64'(im2), 64'(0));
        chk("rst_sop", 64'(sop2), 64'(0));
        chk("rst_eop", 64'(eop2), 64'(0));
        chk("rst_ir", 64'(ir2), 64'(1));
        chk("rst_ir0", 64'(ir0), 64'(1));
        chk("rst_ir8", 64'(ir8), 64'(1));

        // Single symbol to all three builds; first sample valid one cycle after acceptance.
        q2.delete(); q0.delete(); q8.delete();
        drive_sym(0);
        iv2 = 1'b1; iv0 = 1'b1; iv8 = 1'b1;
        cyc();
        iv2 = 1'b0; iv0 = 1'b0; iv8 = 1'b0;
        chk("single_acc", 64'(acc2), 64'(1));
        chk("lat_ov_t", 64'(ov2), 64'(0));
        cyc();
        chk("lat_ov_t1", 64'(ov2), 64'(1));
        chk("first_re", 64'(re2), 64'(16'd7));
        chk("first_im", 64'(im2), 64'(16'hFFF9));
        chk("first_sop", 64'(sop2), 64'(1));
        for (int i = 0; i < 20; i++) cyc();
        check_stream("single", q2, 2, 0, 1);
        check_stream("cp0", q0, 0, 0, 1);
        check_stream("cp8", q8, 8, 0, 1);
        chk("single_idle", 64'(ov2), 64'(0));

        // Back-to-back with out_ready high, then with pseudo-random backpressure.
        run_stream(1'b0, 200);
        check_stream("b2b", q2, 2, 1, 3);
        for (int i = 0; i < 3; i++) cyc();
        run_stream(1'b1, 500);
        check_stream("bp", q2, 2, 1, 3);
        for (int i = 0; i < 3; i++) cyc();

        // Extreme values pass through bit-exact.
        for (int k = 0; k < 8; k++) begin
            sre[0][k] = 16'h8000;
            sim[0][k] = 16'h7FFF;
        end
        q2.delete(); q0.delete(); q8.delete();
        drive_sym(0);
        iv2 = 1'b1; iv0 = 1'b1; iv8 = 1'b1;
        cyc();
        iv2 = 1'b0; iv0 = 1'b0; iv8 = 1'b0;
        for (int i = 0; i < 22; i++) cyc();
        check_stream("ext", q2, 2, 0, 1);
        check_stream("ext_cp0", q0, 0, 0, 1);
        check_stream("ext_cp8", q8, 8, 0, 1);

        // Reset mid-symbol discards everything.
        drive_sym(1);
        iv2 = 1'b1;
        cyc();
        drive_sym(2);
        cyc();
        iv2 = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("mid_ov_before", 64'(ov2), 64'(1));
        rst = 1'b1;
        cyc();
        chk("mid_rst_ov", 64'(ov2), 64'(0));
        chk("mid_rst_re", 64'(re2), 64'(0));
        cyc();
        cyc();
        rst = 1'b0;
        chk("mid_rel_ir", 64'(ir2), 64'(1));
        chk("mid_rel_ov", 64'(ov2), 64'(0));
        q2.delete();
        for (int i = 0; i < 15; i++) cyc();
        chk("mid_no_output", 64'(q2.size()), 64'(0));
        chk("mid_idle_ov", 64'(ov2), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
